// File: rtl/vga_pkg.sv
// Shared VGA timing constants and count widths used by the sync generator and the sprite drawers.
package vga_pkg;
    localparam int XMAX      = 800;
    localparam int YMAX      = 525;
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int CLK_DIV   = 2;

    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int X_W = $clog2(XMAX);
    localparam int Y_W = $clog2(YMAX);

    typedef logic [X_W-1:0] x_count_t;
    typedef logic [Y_W-1:0] y_count_t;

    // Inclusive unsigned window test on zero-extended 32-bit values.
    function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel coordinate / sync bundle from the timing stage to the display path.
interface vga_sync_gen_if
    import vga_pkg::*;
#(
    parameter int XW = X_W,
    parameter int YW = Y_W
);
    logic [XW-1:0] x_count;
    logic [YW-1:0] y_count;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          pixel_tick;
    logic          frame_start;

    modport master (output x_count, y_count, hsync, vsync, active, pixel_tick, frame_start);
    modport slave  (input  x_count, y_count, hsync, vsync, active, pixel_tick, frame_start);
endinterface

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo-MOD counter with enable; at_max flags the terminal count so callers can chain wraps.
module mod_counter
    import vga_pkg::*;
#(
    parameter int MOD = 2,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max
);
    assign at_max = (32'(cnt) == 32'(MOD - 1));

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            cnt <= '0;
        else if (en)
            cnt <= at_max ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, X/Y scan counters, sync/active decode, frame strobe.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int XMAX      = vga_pkg::XMAX,
    parameter int YMAX      = vga_pkg::YMAX,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int CLK_DIV   = vga_pkg::CLK_DIV
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    vga_sync_gen_if.master vga
);
    localparam int XW    = $clog2(XMAX);
    localparam int YW    = $clog2(YMAX);
    localparam int HS_LO = H_VISIBLE + H_FRONT;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_VISIBLE + V_FRONT;
    localparam int VS_HI = VS_LO + V_SYNC - 1;

    if (H_VISIBLE + H_FRONT + H_SYNC + H_BACK != XMAX) begin : g_chk_h
        $fatal(1, "horizontal timing does not sum to XMAX");
    end
    if (V_VISIBLE + V_FRONT + V_SYNC + V_BACK != YMAX) begin : g_chk_v
        $fatal(1, "vertical timing does not sum to YMAX");
    end
    if (CLK_DIV < 1) begin : g_chk_div
        $fatal(1, "CLK_DIV must be at least 1");
    end

    logic          tick;
    logic          x_max;
    logic          y_max;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          frame_start;

    if (CLK_DIV > 1) begin : g_div
        logic [$clog2(CLK_DIV)-1:0] div_cnt;
        logic                       unused_div;
        assign unused_div = ^div_cnt;
        mod_counter #(.MOD(CLK_DIV), .W($clog2(CLK_DIV))) u_div (
            .i_Clk(i_Clk), .i_Reset(i_Reset), .en(1'b1), .cnt(div_cnt), .at_max(tick)
        );
    end else begin : g_nodiv
        assign tick = 1'b1;
    end

    mod_counter #(.MOD(XMAX), .W(XW)) u_x (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .en(tick), .cnt(x_cnt), .at_max(x_max)
    );

    mod_counter #(.MOD(YMAX), .W(YW)) u_y (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .en(tick & x_max), .cnt(y_cnt), .at_max(y_max)
    );

    // Registered on the wrap edge, so it lines up with the first (0,0) cycle.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            frame_start <= 1'b0;
        else
            frame_start <= tick & x_max & y_max;
    end

    assign vga.x_count     = x_cnt;
    assign vga.y_count     = y_cnt;
    assign vga.hsync       = ~in_range(32'(x_cnt), HS_LO, HS_HI);
    assign vga.vsync       = ~in_range(32'(y_cnt), VS_LO, VS_HI);
    assign vga.active      = (32'(x_cnt) < 32'(H_VISIBLE)) && (32'(y_cnt) < 32'(V_VISIBLE));
    assign vga.pixel_tick  = tick;
    assign vga.frame_start = frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks three timing configurations against an elapsed-clock arithmetic model of the scan.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec = 0;
    int   miss = 0;
    int   e0 = 0, e1 = 0, e2 = 0;

    always #5 clk = ~clk;

    vga_sync_gen_if #(.XW(10), .YW(10)) if0 ();
    vga_sync_gen_if #(.XW(6),  .YW(5))  if1 ();
    vga_sync_gen_if #(.XW(6),  .YW(5))  if2 ();

    vga_sync_gen dut0 (.i_Clk(clk), .i_Reset(rst), .vga(if0));
    vga_sync_gen #(.XMAX(40), .YMAX(25), .H_VISIBLE(24), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                   .V_VISIBLE(15), .V_FRONT(3), .V_SYNC(2), .V_BACK(5), .CLK_DIV(2))
        dut1 (.i_Clk(clk), .i_Reset(rst), .vga(if1));
    vga_sync_gen #(.XMAX(40), .YMAX(25), .H_VISIBLE(24), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
                   .V_VISIBLE(15), .V_FRONT(3), .V_SYNC(2), .V_BACK(5), .CLK_DIV(1))
        dut2 (.i_Clk(clk), .i_Reset(rst), .vga(if2));

    // Clock edges seen since reset was last released.
    always @(posedge clk or posedge rst) begin
        if (rst) begin e0 <= 0; e1 <= 0; e2 <= 0; end
        else begin e0 <= e0 + 1; e1 <= e1 + 1; e2 <= e2 + 1; end
    end

    typedef struct packed {
        logic [31:0] x, y;
        logic hs, vs, act, tick, fs;
    } exp_t;

    // After e edges the scan has completed e/d pixel periods; everything follows from that.
    function automatic exp_t model(int e, int d, int xm, int ym, int hv, int hf, int hsw,
                                   int vv, int vf, int vsw);
        exp_t m;
        int p = e / d;
        m.x    = p % xm;
        m.y    = (p / xm) % ym;
        m.hs   = !(int'(m.x) >= hv + hf && int'(m.x) <= hv + hf + hsw - 1);
        m.vs   = !(int'(m.y) >= vv + vf && int'(m.y) <= vv + vf + vsw - 1);
        m.act  = (int'(m.x) < hv) && (int'(m.y) < vv);
        m.tick = (d == 1) ? 1'b1 : (e % d == d - 1);
        m.fs   = (e > 0) && (e % (d * xm * ym) == 0);
        return m;
    endfunction

    task automatic check(string nm, int e, exp_t m, logic [31:0] ax, logic [31:0] ay,
                         logic hs, logic vs, logic act, logic tk, logic fs);
        vec++;
        if (ax != m.x || ay != m.y || hs != m.hs || vs != m.vs || act != m.act ||
            tk != m.tick || fs != m.fs) begin
            miss++;
            $display("FAIL %s e=%0d got x=%0d y=%0d hs=%b vs=%b act=%b tick=%b fs=%b required x=%0d y=%0d hs=%b vs=%b act=%b tick=%b fs=%b",
                     nm, e, ax, ay, hs, vs, act, tk, fs, m.x, m.y, m.hs, m.vs, m.act, m.tick, m.fs);
        end
    endtask

    task automatic lit(string nm, int got, int want);
        vec++;
        if (got != want) begin
            miss++;
            $display("FAIL %s got %0d required %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) if ($time > 2) begin
        check("dut0", e0, model(e0, 2, 800, 525, 640, 16, 96, 480, 10, 2),
              32'(if0.x_count), 32'(if0.y_count), if0.hsync, if0.vsync, if0.active,
              if0.pixel_tick, if0.frame_start);
        check("dut1", e1, model(e1, 2, 40, 25, 24, 4, 6, 15, 3, 2),
              32'(if1.x_count), 32'(if1.y_count), if1.hsync, if1.vsync, if1.active,
              if1.pixel_tick, if1.frame_start);
        check("dut2", e2, model(e2, 1, 40, 25, 24, 4, 6, 15, 3, 2),
              32'(if2.x_count), 32'(if2.y_count), if2.hsync, if2.vsync, if2.active,
              if2.pixel_tick, if2.frame_start);
    end

    initial begin
        int cyc, hs_low, hs_min, hs_max, act_low, fs1, fs2, fs1_first;
        bit done;
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        lit("rst_x", int'(if0.x_count), 0);
        lit("rst_y", int'(if0.y_count), 0);
        lit("rst_hs_vs_act", int'({if0.hsync, if0.vsync, if0.active}), 7);
        lit("rst_tick_fs", int'({if0.pixel_tick, if0.frame_start}), 0);
        lit("rst_tick_div1", int'(if2.pixel_tick), 1);
        #1 rst = 1'b0;

        @(posedge clk); #1;
        lit("first_tick", int'(if0.pixel_tick), 1);
        lit("first_tick_x", int'(if0.x_count), 0);
        @(posedge clk); #1;
        lit("second_clk_x", int'(if0.x_count), 1);

        // Scan line 0 of the default configuration one pixel tick at a time.
        cyc = 2; hs_low = 0; hs_min = 9999; hs_max = -1; act_low = 0; done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (if0.y_count != 0) done = 1;
            else if (if0.pixel_tick) begin
                if (!if0.hsync) begin
                    hs_low++;
                    if (int'(if0.x_count) < hs_min) hs_min = int'(if0.x_count);
                    if (int'(if0.x_count) > hs_max) hs_max = int'(if0.x_count);
                end
                if (!if0.active) act_low++;
            end
        end
        lit("line_clocks", cyc, 1600);
        lit("line_wrap_x", int'(if0.x_count), 0);
        lit("line_wrap_y", int'(if0.y_count), 1);
        lit("hs_low_pixels", hs_low, 96);
        lit("hs_first", hs_min, 656);
        lit("hs_last", hs_max, 751);
        lit("act_low_pixels", act_low, 160);

        // Frame strobes on the small configurations: 2000 and 1000 clocks per frame.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        fs1 = 0; fs2 = 0; fs1_first = -1;
        for (int i = 1; i <= 4200; i++) begin
            @(posedge clk); #1;
            if (if1.frame_start) begin
                fs1++;
                if (fs1_first < 0) fs1_first = i;
                lit("fs1_xy", int'({if1.x_count, if1.y_count}), 0);
            end
            if (if2.frame_start) fs2++;
        end
        lit("fs1_cycles", fs1, 2);
        lit("fs1_first_edge", fs1_first, 2000);
        lit("fs2_cycles", fs2, 4);

        // Random mid-frame resets; the per-cycle model covers recovery and frame strobes.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(20, 2500)) @(posedge clk);
            #($urandom_range(1, 3)) rst = 1'b1;
            #1;
            lit("async_x0", int'(if0.x_count), 0);
            lit("async_xy1", int'({if1.x_count, if1.y_count}), 0);
            lit("async_fs", int'({if0.frame_start, if1.frame_start, if2.frame_start}), 0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #2 rst = 1'b0;
        end
        repeat (2100) @(posedge clk);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for the whole display path. Produces the pixel coordinates (o_X_Count/o_Y_Count) consumed by the bird controller and the other sprite/pipe drawers.
- Generates the VGA sync pulses (640x480@60, 800x525 total) from the system clock, using a pixel-tick divider.
- Provides active-video and frame-start indications for the colour mux and the game-logic stepping.

Parameters:
- XMAX, 800, total horizontal pixel periods per line
- YMAX, 525, total lines per frame
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- CLK_DIV, 2, system clocks per pixel (>=1)

Ports:
- i_Clk  input  1  system clock
- i_Reset  input  1  asynchronous, active-high reset
- o_X_Count  output  $clog2(XMAX)  current pixel column, 0..XMAX-1
- o_Y_Count  output  $clog2(YMAX)  current line, 0..YMAX-1
- o_HSync  output  1  horizontal sync, active-low
- o_VSync  output  1  vertical sync, active-low
- o_Active  output  1  high when X<H_VISIBLE and Y<V_VISIBLE
- o_Pixel_Tick  output  1  one-clock strobe marking the last system clock of each pixel period
- o_Frame_Start  output  1  one-clock pulse when counters wrap from (XMAX-1,YMAX-1) to (0,0)

Behaviour:
- Reset: i_Reset is asynchronous and active-high; i_Clk is the clock.
  - Divider, X and Y counters all clear to 0.
  - While in reset: o_X_Count=0, o_Y_Count=0, o_HSync=1, o_VSync=1, o_Active=1, o_Frame_Start=0.
  - o_Pixel_Tick=0 during reset, except when CLK_DIV=1 (then it is constant 1).
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - o_Pixel_Tick = (div == CLK_DIV-1).
  - CLK_DIV=1: no divider register; tick is tied high.
- Horizontal counter: advances only on a clock edge where the tick is high. At XMAX-1 it wraps to 0; otherwise it increments by 1.
- Vertical counter: advances only on a tick edge where X == XMAX-1. At YMAX-1 it wraps to 0; otherwise it increments by 1.
- Decoded outputs (o_HSync, o_VSync, o_Active) are combinational decodes of the registered counters. They have zero latency relative to o_X_Count/o_Y_Count, so downstream compares stay aligned.
  - o_HSync = 0 iff H_VISIBLE+H_FRONT <= X <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751 at defaults).
  - o_VSync = 0 iff V_VISIBLE+V_FRONT <= Y <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491 at defaults).
- o_Frame_Start:
  - Registered; asserted for exactly one system clock, the cycle immediately after the (XMAX-1,YMAX-1) -> (0,0) wrap.
  - Never asserted by reset release alone.
- Elaboration checks (fatal on failure):
  - H_VISIBLE+H_FRONT+H_SYNC+H_BACK == XMAX
  - V_VISIBLE+V_FRONT+V_SYNC+V_BACK == YMAX
- Reset mid-frame: counters return to (0,0) immediately (asynchronously). Counting restarts on the first tick after release; no partial-frame o_Frame_Start.
- Counter widths are exactly $clog2(XMAX)/$clog2(YMAX). Comparisons are unsigned and zero-extended to 32 bits. No intermediate overflow.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (XMAX, YMAX, porch/sync widths);
  - derived constants H_SYNC_START/H_SYNC_END/V_SYNC_START/V_SYNC_END;
  - the X/Y count widths, so the bird controller and other drawers share identical widths.
- One natural sub-module: mod_counter (parameterised modulus, enable input, wrap-strobe output), instantiated three times (divider, X, Y).

Test Plan:
- Reset held 5 clocks, then released -> counts 0/0, o_HSync=1, o_VSync=1, o_Active=1, o_Frame_Start=0; with CLK_DIV=2 the first tick occurs at the 2nd clock after release and X becomes 1.
- Run one line (CLK_DIV=2) -> o_Pixel_Tick every 2nd clock; X steps 0..799, then wraps to 0 with Y 0->1; 1600 clocks per line.
- Scan line 0 -> o_HSync low exactly for X=656..751 (96 pixels); o_Active low from X=640 through 799.
- Run to lines 489..492 -> o_VSync low only on Y=490 and 491; o_Active=0 for all Y>=480.
- Run two full frames -> exactly one o_Frame_Start per 420000 pixel ticks (840000 clocks at CLK_DIV=2), each one system clock wide, coincident with X=0,Y=0.
- Assert i_Reset at X=300,Y=200, release -> outputs return to reset values asynchronously; the next o_Frame_Start occurs only after a complete 800x525 frame.
